// File: rtl/ldst_mem_unit_pkg.sv
// Shared definitions for the load/store memory unit: opcode constants, ROB tag width, FSM states.
package ldst_mem_unit_pkg;
  localparam int ROBEN_W = 5;
  localparam int RD_W    = 5;
  localparam int OPC_W   = 12;
  localparam int XLEN    = 32;

  localparam logic [OPC_W-1:0] OPC_LW = 12'h003;
  localparam logic [OPC_W-1:0] OPC_SW = 12'h023;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_BCAST  = 2'd2
  } ldst_state_e;

  function automatic logic is_mem_opc(input logic [OPC_W-1:0] opc);
    return (opc == OPC_LW) || (opc == OPC_SW);
  endfunction
endpackage

// File: rtl/ldst_latency_counter.sv
// Down-counter tracking the remaining data-memory read latency; loads MEM_LATENCY-1 on issue.
module ldst_latency_counter #(
  parameter int MEM_LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic dec,
  output logic zero
);
  localparam int CNT_W = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (load)
      cnt_d = CNT_W'(MEM_LATENCY - 1);
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/ldst_mem_unit.sv
// Load/store execution unit: takes one issued lw/sw, accesses data memory, broadcasts the result on its CDB slot.
module ldst_mem_unit
  import ldst_mem_unit_pkg::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_VALID_Inst,
  input  logic [ROBEN_W-1:0]   in_ROBEN,
  input  logic [RD_W-1:0]      in_Rd,
  input  logic [OPC_W-1:0]     in_opcode,
  input  logic [XLEN-1:0]      in_EA,
  input  logic [XLEN-1:0]      in_ROBEN2_VAL,
  input  logic                 ROB_FLUSH_Flag,
  output logic                 in_BUSY,
  input  logic                 cdb_grant,
  output logic                 out_CDB_VALID,
  output logic [ROBEN_W-1:0]   out_CDB_ROBEN,
  output logic [RD_W-1:0]      out_CDB_Rd,
  output logic [XLEN-1:0]      out_CDB_VAL,
  output logic                 out_EXCEPTION,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_we,
  output logic [XLEN-1:0]      mem_wdata,
  input  logic [XLEN-1:0]      mem_rdata
);
  ldst_state_e          state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 cdb_valid_q, cdb_valid_d;
  logic [ROBEN_W-1:0]   cdb_roben_q, cdb_roben_d;
  logic [RD_W-1:0]      cdb_rd_q, cdb_rd_d;
  logic [XLEN-1:0]      cdb_val_q, cdb_val_d;
  logic                 exc_q, exc_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]      mem_wdata_q, mem_wdata_d;
  logic [ROBEN_W-1:0]   op_roben_q, op_roben_d;
  logic [RD_W-1:0]      op_rd_q, op_rd_d;
  logic                 op_is_lw_q, op_is_lw_d;
  logic                 cnt_load, cnt_dec, cnt_zero;
  logic                 bad_access;

  // Misaligned, beyond the memory depth, or not a memory opcode: reported, never touches memory.
  assign bad_access = (in_EA[1:0] != 2'b00) || (in_EA[XLEN-1:ADDR_BITS+2] != '0) || !is_mem_opc(in_opcode);

  always_comb begin
    state_d     = state_q;
    cdb_valid_d = cdb_valid_q;
    cdb_roben_d = cdb_roben_q;
    cdb_rd_d    = cdb_rd_q;
    cdb_val_d   = cdb_val_q;
    exc_d       = exc_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    op_roben_d  = op_roben_q;
    op_rd_d     = op_rd_q;
    op_is_lw_d  = op_is_lw_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_VALID_Inst && (in_ROBEN != '0)) begin
          op_roben_d = in_ROBEN;
          op_rd_d    = in_Rd;
          op_is_lw_d = (in_opcode == OPC_LW);
          if (bad_access) begin
            state_d     = S_BCAST;
            cdb_valid_d = 1'b1;
            exc_d       = 1'b1;
            cdb_val_d   = '0;
            cdb_roben_d = in_ROBEN;
            cdb_rd_d    = in_Rd;
          end else begin
            state_d    = S_ACCESS;
            mem_addr_d = in_EA[ADDR_BITS+1:2];
            cnt_load   = 1'b1;
            if (in_opcode == OPC_SW) begin
              mem_we_d    = 1'b1;
              mem_wdata_d = in_ROBEN2_VAL;
            end
          end
        end
      end
      S_ACCESS: begin
        if (cnt_zero) begin
          state_d     = S_BCAST;
          cdb_valid_d = 1'b1;
          exc_d       = 1'b0;
          cdb_val_d   = op_is_lw_q ? mem_rdata : '0;
          cdb_roben_d = op_roben_q;
          cdb_rd_d    = op_rd_q;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_BCAST: begin
        if (cdb_grant) begin
          state_d     = S_IDLE;
          cdb_valid_d = 1'b0;
          exc_d       = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A squash overrides any accept or grant in the same cycle; written stores are not undone.
    if (ROB_FLUSH_Flag) begin
      state_d     = S_IDLE;
      cdb_valid_d = 1'b0;
      exc_d       = 1'b0;
      cdb_roben_d = '0;
      cdb_rd_d    = '0;
      cdb_val_d   = '0;
      mem_we_d    = 1'b0;
      cnt_load    = 1'b0;
    end
  end

  assign busy_d = (state_d != S_IDLE);

  always_ff @(posedge clk) begin
    mem_addr_q  <= mem_addr_d;
    mem_wdata_q <= mem_wdata_d;
    op_roben_q  <= op_roben_d;
    op_rd_q     <= op_rd_d;
    op_is_lw_q  <= op_is_lw_d;
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      cdb_valid_q <= 1'b0;
      cdb_roben_q <= '0;
      cdb_rd_q    <= '0;
      cdb_val_q   <= '0;
      exc_q       <= 1'b0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_roben_q <= cdb_roben_d;
      cdb_rd_q    <= cdb_rd_d;
      cdb_val_q   <= cdb_val_d;
      exc_q       <= exc_d;
      mem_we_q    <= mem_we_d;
    end
  end

  ldst_latency_counter #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_lat_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (ROB_FLUSH_Flag),
    .load (cnt_load),
    .dec  (cnt_dec),
    .zero (cnt_zero)
  );

  assign in_BUSY       = busy_q;
  assign out_CDB_VALID = cdb_valid_q;
  assign out_CDB_ROBEN = cdb_roben_q;
  assign out_CDB_Rd    = cdb_rd_q;
  assign out_CDB_VAL   = cdb_val_q;
  assign out_EXCEPTION = exc_q;
  assign mem_addr      = mem_addr_q;
  assign mem_we        = mem_we_q;
  assign mem_wdata     = mem_wdata_q;
endmodule

// File: tb/tb_ldst_mem_unit.sv
// Scoreboard bench for ldst_mem_unit with a one-register synchronous data memory model.
module tb_ldst_mem_unit;
  localparam logic [11:0] LW = 12'h003;
  localparam logic [11:0] SW = 12'h023;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_VALID_Inst = 1'b0;
  logic [4:0]  in_ROBEN = '0;
  logic [4:0]  in_Rd = '0;
  logic [11:0] in_opcode = '0;
  logic [31:0] in_EA = '0;
  logic [31:0] in_ROBEN2_VAL = '0;
  logic        ROB_FLUSH_Flag = 1'b0;
  logic        in_BUSY;
  logic        cdb_grant = 1'b1;
  logic        out_CDB_VALID;
  logic [4:0]  out_CDB_ROBEN;
  logic [4:0]  out_CDB_Rd;
  logic [31:0] out_CDB_VAL;
  logic        out_EXCEPTION;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  typedef struct packed {
    logic [4:0]  roben;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        exc;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  logic [9:0]  we_addr = '0;
  logic [31:0] we_data = '0;

  always #5 clk = ~clk;

  ldst_mem_unit dut (
    .clk(clk), .rst(rst), .in_VALID_Inst(in_VALID_Inst), .in_ROBEN(in_ROBEN), .in_Rd(in_Rd),
    .in_opcode(in_opcode), .in_EA(in_EA), .in_ROBEN2_VAL(in_ROBEN2_VAL), .ROB_FLUSH_Flag(ROB_FLUSH_Flag),
    .in_BUSY(in_BUSY), .cdb_grant(cdb_grant), .out_CDB_VALID(out_CDB_VALID), .out_CDB_ROBEN(out_CDB_ROBEN),
    .out_CDB_Rd(out_CDB_Rd), .out_CDB_VAL(out_CDB_VAL), .out_EXCEPTION(out_EXCEPTION), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt++;
      we_addr = mem_addr;
      we_data = mem_wdata;
    end
    if (!rst && out_CDB_VALID && cdb_grant) begin
      if (exp_q.size() == 0) begin
        chk("cdb_unexpected_roben", 32'(out_CDB_ROBEN), 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("cdb_roben", 32'(out_CDB_ROBEN), 32'(e.roben));
        chk("cdb_rd", 32'(out_CDB_Rd), 32'(e.rd));
        chk("cdb_val", out_CDB_VAL, e.val);
        chk("cdb_exc", 32'(out_EXCEPTION), 32'(e.exc));
      end
    end
  end

  task automatic issue(input logic [4:0] rb, input logic [4:0] rd, input logic [11:0] opc,
                       input logic [31:0] ea, input logic [31:0] d,
                       input bit exp_bc, input logic [31:0] ev, input bit ee);
    int n = 0;
    while (in_BUSY && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_BUSY) chk("issue_wait_busy", 32'(in_BUSY), 32'h0);
    in_VALID_Inst = 1'b1;
    in_ROBEN = rb;
    in_Rd = rd;
    in_opcode = opc;
    in_EA = ea;
    in_ROBEN2_VAL = d;
    if (exp_bc) exp_q.push_back('{roben: rb, rd: rd, val: ev, exc: ee});
    @(posedge clk); #1;
    in_VALID_Inst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || in_BUSY) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    int n;
    int we_base;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(in_BUSY), 32'h0);
    chk("rst_valid", 32'(out_CDB_VALID), 32'h0);
    chk("rst_roben", 32'(out_CDB_ROBEN), 32'h0);
    chk("rst_val", out_CDB_VAL, 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    rst = 1'b0;
    pre_we = 1'b1; pre_addr = 10'd4; pre_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    pre_we = 1'b0;

    // Load latency: request visible after the third edge counting the accept edge
    issue(5'd3, 5'd9, LW, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    n = 1;
    while (!out_CDB_VALID && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("lw_latency", 32'(n), 32'd3);
    drain();

    // Store then load the same word
    we_base = we_cnt;
    issue(5'd4, 5'd0, SW, 32'h20, 32'h12345678, 1'b1, 32'h0, 1'b0);
    drain();
    chk("sw_we_cycles", 32'(we_cnt - we_base), 32'd1);
    chk("sw_we_addr", 32'(we_addr), 32'd8);
    chk("sw_we_data", we_data, 32'h12345678);
    issue(5'd5, 5'd6, LW, 32'h20, 32'h0, 1'b1, 32'h12345678, 1'b0);
    drain();

    // Grant withheld: outputs hold, issue ignored
    cdb_grant = 1'b0;
    issue(5'd10, 5'd11, LW, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    n = 0;
    while (!out_CDB_VALID && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    in_VALID_Inst = 1'b1; in_ROBEN = 5'd9; in_opcode = LW; in_EA = 32'h20;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(out_CDB_VALID), 32'h1);
      chk("stall_roben", 32'(out_CDB_ROBEN), 32'd10);
      chk("stall_val", out_CDB_VAL, 32'hDEADBEEF);
      chk("stall_busy", 32'(in_BUSY), 32'h1);
    end
    in_VALID_Inst = 1'b0;
    cdb_grant = 1'b1;
    @(posedge clk); #1;
    chk("grant_valid_drop", 32'(out_CDB_VALID), 32'h0);
    chk("grant_busy_drop", 32'(in_BUSY), 32'h0);
    drain();

    // Flush during ACCESS
    issue(5'd7, 5'd1, LW, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0);
    ROB_FLUSH_Flag = 1'b1;
    @(posedge clk); #1;
    ROB_FLUSH_Flag = 1'b0;
    chk("flush_busy", 32'(in_BUSY), 32'h0);
    chk("flush_valid", 32'(out_CDB_VALID), 32'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("flush_no_bcast", 32'(out_CDB_VALID), 32'h0);
    issue(5'd8, 5'd2, LW, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    drain();

    // Exceptions: misaligned, out of range, unknown opcode, misaligned store
    we_base = we_cnt;
    issue(5'd12, 5'd3, LW, 32'h13, 32'h0, 1'b1, 32'h0, 1'b1);
    drain();
    issue(5'd13, 5'd3, LW, 32'h1000, 32'h0, 1'b1, 32'h0, 1'b1);
    drain();
    issue(5'd14, 5'd3, 12'h7FF, 32'h10, 32'h0, 1'b1, 32'h0, 1'b1);
    drain();
    issue(5'd15, 5'd0, SW, 32'h22, 32'hCAFEF00D, 1'b1, 32'h0, 1'b1);
    drain();
    chk("exc_no_write", 32'(we_cnt - we_base), 32'd0);

    // ROBEN 0 ignored
    in_VALID_Inst = 1'b1; in_ROBEN = 5'd0; in_opcode = LW; in_EA = 32'h10;
    @(posedge clk); #1;
    in_VALID_Inst = 1'b0;
    chk("roben0_busy", 32'(in_BUSY), 32'h0);

    // Back-to-back loads
    issue(5'd1, 5'd20, LW, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    issue(5'd2, 5'd21, LW, 32'h20, 32'h0, 1'b1, 32'h12345678, 1'b0);
    drain();

    // Reset while the store strobe is high
    issue(5'd16, 5'd0, SW, 32'h40, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0);
    chk("pre_rst_we", 32'(mem_we), 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_we", 32'(mem_we), 32'h0);
    chk("mid_rst_busy", 32'(in_BUSY), 32'h0);
    chk("mid_rst_valid", 32'(out_CDB_VALID), 32'h0);
    chk("mid_rst_roben", 32'(out_CDB_ROBEN), 32'h0);
    chk("mid_rst_exc", 32'(out_EXCEPTION), 32'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(out_CDB_VALID), 32'h0);
    issue(5'd17, 5'd22, LW, 32'h40, 32'h0, 1'b1, 32'hA5A5A5A5, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
